// File: rtl/ram_peek_streamer.sv
// ram_peek_streamer
//   Drains LENGTH consecutive words, starting at BASE, out of a node RAM through
//   its 1-cycle-latency peek port and presents them on a valid/ready stream with
//   a last flag. Reads are credit-limited so the output FIFO can never overflow.
//
//   Optional feature macro: STREAM_CHECKSUM_EN
//     defined     -> 32-bit running sum of every streamed beat on port `checksum`
//     not defined -> no checksum port and no adder
module ram_peek_streamer #(
  parameter int RAM_SIZE   = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] length,
  output logic        busy,
  output logic        done,
  output logic [31:0] peekAddress,
  input  logic [31:0] peekData,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last
`ifdef STREAM_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int AW = $clog2(RAM_SIZE);   // RAM word-address width
  localparam int PW = $clog2(FIFO_DEPTH); // FIFO pointer width
  localparam int CW = PW + 1;             // FIFO occupancy width (0..FIFO_DEPTH)

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FIN
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic [31:0]     length_q;     // latched transfer length
  logic [31:0]     issued_q;     // reads issued so far in this transfer
  logic [AW-1:0]   next_addr_q;  // address of the next read to issue
  logic [31:0]     peek_addr_q;

  // Two-stage read pipeline: stage 1 = address presented, stage 2 = data on peekData.
  logic            s1_valid_q, s1_last_q;
  logic            s2_valid_q, s2_last_q;

  // Output FIFO, each entry is {last, data}.
  logic [32:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_count_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic            fifo_push;
  logic            fifo_pop;
  logic            beat;
  logic            last_beat;
  logic            issue_read;
  logic [CW:0]     occupancy;
  logic            credit_ok;
  logic [32:0]     fifo_head;

  // Only the low AW address bits matter; the rest wrap away modulo RAM_SIZE.
  logic            unused_base_hi;
  assign unused_base_hi = ^base_addr[31:AW];

  // Words already buffered plus words still in the read pipeline must leave room.
  assign occupancy  = (CW+1)'(fifo_count_q) + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
  assign credit_ok  = occupancy < (CW+1)'(FIFO_DEPTH);

  assign issue_read = (state_q == S_READ) && (issued_q != length_q) && credit_ok;

  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign m_valid    = (fifo_count_q != '0);
  assign m_data     = m_valid ? fifo_head[31:0] : 32'd0;
  assign m_last     = m_valid & fifo_head[32];

  assign beat       = m_valid & m_ready;
  assign last_beat  = beat & m_last;
  assign fifo_push  = s2_valid_q;
  assign fifo_pop   = beat;

  assign busy        = busy_q;
  assign done        = done_q;
  assign peekAddress = peek_addr_q;

  // ---------------------------------------------------------------------------
  // Transfer FSM: accepts start, issues peek reads, tracks drain and completion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      length_q    <= 32'd0;
      issued_q    <= 32'd0;
      next_addr_q <= '0;
      peek_addr_q <= 32'd0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every right-hand side
      // reads the pre-edge value and the pipeline shift below is order-independent.
      done_q     <= 1'b0;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            length_q <= length;
            if (length == 32'd0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              // First read goes out on the accepting edge to save a cycle.
              state_q     <= S_READ;
              busy_q      <= 1'b1;
              peek_addr_q <= 32'(base_addr[AW-1:0]);
              next_addr_q <= base_addr[AW-1:0] + AW'(1);
              issued_q    <= 32'd1;
              s1_valid_q  <= 1'b1;
              s1_last_q   <= (length == 32'd1);
            end
          end
        end

        S_READ: begin
          if (issue_read) begin
            peek_addr_q <= 32'(next_addr_q);
            next_addr_q <= next_addr_q + AW'(1);
            issued_q    <= issued_q + 32'd1;
            s1_valid_q  <= 1'b1;
            s1_last_q   <= (issued_q == length_q - 32'd1);
          end
          if (issued_q == length_q) begin
            state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (last_beat) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop in the same cycle leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // FIFO storage: captures the peek word one edge after it appears on peekData
  // NOTE: storage has no reset; m_data is gated by m_valid, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= {s2_last_q, peekData};
    end
  end

`ifdef STREAM_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running sum of streamed beats, restarted by each accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 32'd0;
    end else if ((state_q == S_IDLE) && start) begin
      checksum_q <= 32'd0;
    end else if (beat) begin
      checksum_q <= checksum_q + m_data;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ram_peek_streamer.sv
// tb_ram_peek_streamer
//   Self-checking bench for ram_peek_streamer. A behavioural RAM answers the
//   peek port; each transfer is predicted as a queue of words read straight
//   from that RAM and compared beat by beat. Build with +define+STREAM_CHECKSUM_EN
//   to also exercise the checksum port.
module tb_ram_peek_streamer;

  localparam int RS = 1024;
  localparam int FD = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] length;
  logic        busy;
  logic        done;
  logic [31:0] peekAddress;
  logic [31:0] peekData;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
`ifdef STREAM_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ram [RS];

  ram_peek_streamer #(.RAM_SIZE(RS), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .peekAddress (peekAddress),
    .peekData    (peekData),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last)
`ifdef STREAM_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: data valid one cycle after the address.
  always @(posedge clk) peekData <= ram[peekAddress % RS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ram();
    for (int i = 0; i < RS; i++) ram[i] = 32'h100 + 32'(i);
  endtask

  // Runs one transfer and checks it against the queue predicted from the RAM.
  // mode 0: m_ready=1, mode 1: pattern 1,0,0,1,0, mode 2: random m_ready.
  task automatic run_transfer(input logic [31:0] base, input int len, input int mode,
                              input bit poke_busy, input string name);
    logic [31:0] exp_q[$];
    logic [31:0] exp_sum;
    logic [31:0] a;
    logic [31:0] last_addr;
    logic [31:0] prev_data;
    logic [4:0]  pat;
    bit          prev_stall, prev_last, done_seen;
    int          beats, reads, budget, t;

    exp_sum = 32'd0;
    for (int i = 0; i < len; i++) begin
      a = base + 32'(i);
      exp_q.push_back(ram[a % RS]);
      exp_sum = exp_sum + ram[a % RS];
    end
    pat = 5'b01001;
    budget = 30 + 8 * len;

    start = 1'b1; base_addr = base; length = 32'(len);
    tick();
    start = 1'b0; base_addr = $urandom; length = $urandom;

    n_checks++;
    if (len != 0 && (peekAddress !== base % RS || busy !== 1'b1))
      $display("FAIL %s launch: peekAddress=%0d busy=%b, expected %0d busy=1", name, peekAddress, busy, base % RS);
    else if (len == 0 && (done !== 1'b1 || busy !== 1'b0))
      $display("FAIL %s len0 launch: done=%b busy=%b, expected done=1 busy=0", name, done, busy);
    else n_pass++;

    reads = (len != 0) ? 1 : 0;
    beats = 0; last_addr = peekAddress; prev_stall = 0; prev_last = 0; prev_data = 0;
    done_seen = 0;

    for (t = 0; t < budget && !done_seen; t++) begin
      if (t > 0 && peekAddress !== last_addr) begin
        reads++;
        n_checks++;
        a = base + 32'(reads) - 32'd1;
        if (peekAddress !== a % RS || reads > len)
          $display("FAIL %s addr #%0d: got %0d, expected %0d (len %0d)", name, reads, peekAddress, a % RS, len);
        else n_pass++;
        last_addr = peekAddress;
      end
      if (reads - beats > FD) begin
        n_checks++;
        $display("FAIL %s read-ahead: %0d reads outstanding, limit %0d", name, reads - beats, FD);
      end
      if (prev_stall) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)
          $display("FAIL %s stall hold t=%0d: v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                   name, t, m_valid, m_data, m_last, prev_data, prev_last);
        else n_pass++;
      end
      if (len == 0 || t < 2) begin
        if (m_valid !== 1'b0) begin
          n_checks++;
          $display("FAIL %s early valid t=%0d: m_valid=%b, expected 0", name, t, m_valid);
        end
      end else if (t == 2) begin
        n_checks++;
        if (m_valid !== 1'b1) $display("FAIL %s first valid t=2: m_valid=%b, expected 1", name, m_valid);
        else n_pass++;
      end

      if (done === 1'b1) begin
        done_seen = 1;
        n_checks++;
        if (beats != len || busy !== 1'b0 || m_valid !== 1'b0)
          $display("FAIL %s at done: beats=%0d busy=%b valid=%b, expected beats=%0d busy=0 valid=0",
                   name, beats, busy, m_valid, len);
        else n_pass++;
        if (mode == 0) begin
          n_checks++;
          if (t != ((len == 0) ? 0 : len + 2))
            $display("FAIL %s done timing: cycle %0d, expected %0d", name, t, (len == 0) ? 0 : len + 2);
          else n_pass++;
        end
`ifdef STREAM_CHECKSUM_EN
        n_checks++;
        if (checksum !== exp_sum) $display("FAIL %s checksum: got %h, expected %h", name, checksum, exp_sum);
        else n_pass++;
`endif
      end else begin
        case (mode)
          0:       m_ready = 1'b1;
          1:       m_ready = pat[t % 5];
          default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (poke_busy && t == 3) begin
          start = 1'b1; base_addr = 32'd77; length = 32'd5;
        end else begin
          start = 1'b0;
        end
        if (m_valid === 1'b1 && m_ready) begin
          n_checks++;
          if (beats >= len)
            $display("FAIL %s extra beat: data=%h, expected no beat after %0d", name, m_data, len);
          else if (m_data !== exp_q[beats] || m_last !== (beats == len - 1))
            $display("FAIL %s beat %0d: data=%h last=%b, expected data=%h last=%b",
                     name, beats, m_data, m_last, exp_q[beats], (beats == len - 1));
          else n_pass++;
          beats++;
        end
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        tick();
      end
    end
    start = 1'b0;

    if (!done_seen) begin
      n_checks++;
      $display("FAIL %s timeout: no done within %0d cycles, beats=%0d expected %0d", name, budget, beats, len);
    end

    m_ready = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL %s after done: done=%b busy=%b valid=%b, expected 0 0 0", name, done, busy, m_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = 32'd0; length = 32'd0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        m_data !== 32'd0 || peekAddress !== 32'd0)
      $display("FAIL reset state: busy=%b done=%b valid=%b last=%b data=%h addr=%h, expected all 0",
               busy, done, m_valid, m_last, m_data, peekAddress);
    else n_pass++;
`ifdef STREAM_CHECKSUM_EN
    n_checks++;
    if (checksum !== 32'd0) $display("FAIL reset checksum: got %h, expected 0", checksum);
    else n_pass++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    init_ram();
    run_transfer(32'd0, 9, 0, 0, "stream9");
    run_transfer(32'd0, 9, 1, 0, "stall9");
    run_transfer(32'd1022, 4, 0, 0, "wrap");
    n_checks++;
    if (ram[1022] !== 32'h4FE || ram[1] !== 32'h101)
      $display("FAIL wrap ram image: %h %h, expected 4fe 101", ram[1022], ram[1]);
    else n_pass++;
  endtask

  task automatic test_len_zero_and_busy_start();
    init_ram();
    run_transfer(32'd5, 0, 0, 0, "len0");
    run_transfer(32'd10, 9, 0, 1, "busy_start");
  endtask

  task automatic test_mid_reset();
    int beats;
    init_ram();
    start = 1'b1; base_addr = 32'd0; length = 32'd9; m_ready = 1'b1;
    tick();
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 3; c++) begin
      if (m_valid === 1'b1) beats++;
      tick();
    end
    n_checks++;
    if (beats != 3) $display("FAIL midreset setup: %0d beats, expected 3", beats);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        m_data !== 32'd0 || peekAddress !== 32'd0)
      $display("FAIL midreset outputs: busy=%b done=%b valid=%b last=%b data=%h addr=%h, expected all 0",
               busy, done, m_valid, m_last, m_data, peekAddress);
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done !== 1'b0 || m_valid !== 1'b0) begin
        n_checks++;
        $display("FAIL midreset aftermath cycle %0d: done=%b valid=%b, expected 0 0", c, done, m_valid);
      end
    end
    run_transfer(32'd4, 2, 0, 0, "post_reset");
  endtask

  task automatic test_random();
    logic [31:0] b;
    int          l;
    for (int i = 0; i < RS; i++) ram[i] = $urandom;
    for (int k = 0; k < 8; k++) begin
      b = $urandom_range(0, RS - 1);
      l = $urandom_range(1, 24);
      run_transfer(b, l, 2, 0, "random");
    end
    run_transfer(32'd1000, RS + 6, 0, 0, "long_wrap");
  endtask

  task automatic test_checksum();
`ifdef STREAM_CHECKSUM_EN
    init_ram();
    for (int i = 0; i < 9; i++) ram[i] = (i == 4) ? 32'd2 : 32'd1;
    run_transfer(32'd0, 9, 1, 0, "checksum");
    n_checks++;
    if (checksum !== 32'd10) $display("FAIL checksum held: got %0d, expected 10", checksum);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_len_zero_and_busy_start();
    test_mid_reset();
    test_random();
    test_checksum();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
